// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions for the read and write channel masters.
package axil_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } axi_resp_t;

    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axil_sync_fifo.sv
// Synchronous FIFO with registered full/empty flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module axil_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   ONE_C   = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & ~empty_q;
    assign rdata_o = mem_q[rd_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

    always_comb begin
        wr_d  = do_push ? wr_q + PTR_ONE : wr_q;
        rd_d  = do_pop ? rd_q + PTR_ONE : rd_q;
        cnt_d = cnt_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + ONE_C;
            2'b01:   cnt_d = cnt_q - ONE_C;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == DEPTH_C);
            empty_q <= (cnt_d == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/axilm_wr_ch_q.sv
// AXI4-Lite write master: queued requests, independent AW/W issue,
// up to MAX_OUTST writes awaiting B, responses returned in order.
module axilm_wr_ch_q
    import axil_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int REQ_DEPTH = 4,
    parameter int MAX_OUTST = 4
) (
    input  logic                ACLK,
    input  logic                ARESET,
    output logic [ADDR_W-1:0]   AWADDR,
    output logic [2:0]          AWPROT,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    output logic                WVALID,
    input  logic                WREADY,
    input  logic                BVALID,
    output logic                BREADY,
    input  logic [1:0]          BRESP,
    input  logic                BUS_REQ_VALID,
    output logic                BUS_REQ_READY,
    input  logic [ADDR_W-1:0]   BUS_ADDR,
    input  logic [DATA_W/8-1:0] BUS_WSTB,
    input  logic [DATA_W-1:0]   BUS_WDATA,
    output logic                BUS_RSP_VALID,
    input  logic                BUS_RSP_READY,
    output logic [1:0]          BUS_BRESP,
    output logic                BUS_ERR,
    output logic                BUS_IDLE
);

    localparam int SW = DATA_W / 8;
    localparam int EW = ADDR_W + SW + DATA_W;
    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTST);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    logic              fifo_push, fifo_pop;
    logic              fifo_full, fifo_empty;
    logic [EW-1:0]     head;
    logic [ADDR_W-1:0] head_addr;
    logic [SW-1:0]     head_strb;
    logic [DATA_W-1:0] head_data;

    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    axi_resp_t         rsp_q, rsp_d;
    logic              err_q, err_d;
    logic              bready_q;

    logic present, aw_hs, w_hs, b_hs;

    axil_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk_i   (ACLK),
        .rst_i   (ARESET),
        .push_i  (fifo_push),
        .wdata_i ({BUS_ADDR, BUS_WSTB, BUS_WDATA}),
        .pop_i   (fifo_pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign {head_addr, head_strb, head_data} = head;

    // Zero-strobe requests are accepted but never enter the queue.
    assign BUS_REQ_READY = ~fifo_full;
    assign fifo_push     = BUS_REQ_VALID & ~fifo_full & (|BUS_WSTB);

    assign present  = ~fifo_empty & (cnt_q < MAX_C);
    assign AWVALID  = present & ~aw_done_q;
    assign WVALID   = present & ~w_done_q;
    assign AWADDR   = present ? head_addr : '0;
    assign WDATA    = present ? head_data : '0;
    assign WSTRB    = present ? head_strb : '0;
    assign AWPROT   = AXI_PROT_DEFAULT;

    assign aw_hs    = AWVALID & AWREADY;
    assign w_hs     = WVALID & WREADY;
    assign fifo_pop = present & (aw_done_q | aw_hs) & (w_done_q | w_hs);
    assign b_hs     = BVALID & bready_q;

    assign BREADY        = bready_q;
    assign BUS_RSP_VALID = rsp_valid_q;
    assign BUS_BRESP     = rsp_q;
    assign BUS_ERR       = err_q;
    assign BUS_IDLE      = fifo_empty & (cnt_q == '0) & ~rsp_valid_q;

    always_comb begin
        aw_done_d   = fifo_pop ? 1'b0 : (aw_done_q | aw_hs);
        w_done_d    = fifo_pop ? 1'b0 : (w_done_q | w_hs);
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_d       = rsp_q;
        err_d       = err_q | (b_hs & BRESP[1]);
        unique case ({fifo_pop, b_hs})
            2'b10:   cnt_d = cnt_q + ONE_C;
            2'b01:   cnt_d = cnt_q - ONE_C;
            default: cnt_d = cnt_q;
        endcase
        if (b_hs) begin
            rsp_valid_d = 1'b1;
            rsp_d       = axi_resp_t'(BRESP);
        end else if (BUS_RSP_READY) begin
            rsp_valid_d = 1'b0;
        end
    end

    // BREADY is registered so it stays low through reset.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= OKAY;
            err_q       <= 1'b0;
            bready_q    <= 1'b0;
        end else begin
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
            err_q       <= err_d;
            bready_q    <= ~rsp_valid_d;
        end
    end

endmodule

// File: tb/tb_axilm_wr_ch_q.sv
// Scoreboard bench for axilm_wr_ch_q with a randomized AXI-Lite slave.
module tb_axilm_wr_ch_q;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int SW        = DATA_W / 8;
    localparam int REQ_DEPTH = 4;
    localparam int MAX_OUTST = 2;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [SW-1:0]     s;
    } wr_t;

    logic              ACLK = 1'b0;
    logic              ARESET = 1'b1;
    logic [ADDR_W-1:0] AWADDR;
    logic [2:0]        AWPROT;
    logic              AWVALID;
    logic              AWREADY = 1'b0;
    logic [DATA_W-1:0] WDATA;
    logic [SW-1:0]     WSTRB;
    logic              WVALID;
    logic              WREADY = 1'b0;
    logic              BVALID = 1'b0;
    logic              BREADY;
    logic [1:0]        BRESP = 2'd0;
    logic              BUS_REQ_VALID = 1'b0;
    logic              BUS_REQ_READY;
    logic [ADDR_W-1:0] BUS_ADDR = '0;
    logic [SW-1:0]     BUS_WSTB = '0;
    logic [DATA_W-1:0] BUS_WDATA = '0;
    logic              BUS_RSP_VALID;
    logic              BUS_RSP_READY = 1'b0;
    logic [1:0]        BUS_BRESP;
    logic              BUS_ERR;
    logic              BUS_IDLE;

    axilm_wr_ch_q #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .REQ_DEPTH (REQ_DEPTH),
        .MAX_OUTST (MAX_OUTST)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .AWADDR        (AWADDR),
        .AWPROT        (AWPROT),
        .AWVALID       (AWVALID),
        .AWREADY       (AWREADY),
        .WDATA         (WDATA),
        .WSTRB         (WSTRB),
        .WVALID        (WVALID),
        .WREADY        (WREADY),
        .BVALID        (BVALID),
        .BREADY        (BREADY),
        .BRESP         (BRESP),
        .BUS_REQ_VALID (BUS_REQ_VALID),
        .BUS_REQ_READY (BUS_REQ_READY),
        .BUS_ADDR      (BUS_ADDR),
        .BUS_WSTB      (BUS_WSTB),
        .BUS_WDATA     (BUS_WDATA),
        .BUS_RSP_VALID (BUS_RSP_VALID),
        .BUS_RSP_READY (BUS_RSP_READY),
        .BUS_BRESP     (BUS_BRESP),
        .BUS_ERR       (BUS_ERR),
        .BUS_IDLE      (BUS_IDLE)
    );

    always #5 ACLK = ~ACLK;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: expected AXI traffic and responses in issue order.
    wr_t        exp_aw[$];
    wr_t        exp_w[$];
    logic [1:0] exp_rsp[$];
    logic [1:0] slv_rsp[$];
    bit         err_exp = 0;

    int aw_tot = 0, w_tot = 0, b_tot = 0, b_iss = 0;
    int aw_mode = 1, w_mode = 1, rr_mode = 1, b_budget = -1;
    bit bhs_seen = 0;
    int inflight;
    int pairs;
    logic [1:0] mon_r;

    task automatic check_eq(input string n, input logic [63:0] act,
                            input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", n, act, exp);
        end
    endtask

    function automatic logic pick(input int m);
        if (m == 1) return 1'b1;
        if (m == 2) return 1'b0;
        return 1'($urandom_range(0, 1));
    endfunction

    // Monitor: sampled at negedge, handshakes complete at the next posedge.
    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (AWVALID) begin
                if (exp_aw.size() == 0) begin
                    check_eq("aw_unexpected", 64'(AWVALID), 64'(0));
                end else begin
                    check_eq("awaddr", 64'(AWADDR), 64'(exp_aw[0].a));
                    if (AWREADY) begin
                        void'(exp_aw.pop_front());
                        aw_tot++;
                    end
                end
            end
            if (WVALID) begin
                if (exp_w.size() == 0) begin
                    check_eq("w_unexpected", 64'(WVALID), 64'(0));
                end else begin
                    check_eq("wdata", 64'(WDATA), 64'(exp_w[0].d));
                    check_eq("wstrb", 64'(WSTRB), 64'(exp_w[0].s));
                    if (WREADY) begin
                        void'(exp_w.pop_front());
                        w_tot++;
                    end
                end
            end
            if ((AWVALID && AWREADY) || (WVALID && WREADY)) begin
                inflight = ((aw_tot < w_tot) ? aw_tot : w_tot) - b_tot;
                check_eq("outstanding_le_max", 64'(inflight <= MAX_OUTST), 64'(1));
            end
            if (BVALID && BREADY) begin
                b_tot++;
                bhs_seen = 1;
            end
            if (BUS_RSP_VALID && BUS_RSP_READY) begin
                if (exp_rsp.size() == 0) begin
                    check_eq("rsp_unexpected", 64'(BUS_RSP_VALID), 64'(0));
                end else begin
                    mon_r = exp_rsp.pop_front();
                    err_exp = err_exp | mon_r[1];
                    check_eq("bus_bresp", 64'(BUS_BRESP), 64'(mon_r));
                    check_eq("bus_err", 64'(BUS_ERR), 64'(err_exp));
                end
            end
        end
    end

    // AXI-Lite slave: random readiness, in-order B after AW+W pairs.
    initial forever begin
        @(posedge ACLK);
        #1;
        if (ARESET) begin
            AWREADY = 0;
            WREADY = 0;
            BVALID = 0;
            BRESP = 0;
            BUS_RSP_READY = 0;
            bhs_seen = 0;
        end else begin
            AWREADY = pick(aw_mode);
            WREADY = pick(w_mode);
            BUS_RSP_READY = pick(rr_mode);
            if (!BVALID || bhs_seen) begin
                BVALID = 0;
                bhs_seen = 0;
                pairs = ((aw_tot < w_tot) ? aw_tot : w_tot) - b_iss;
                if (pairs > 0 && b_budget != 0 && slv_rsp.size() > 0
                    && $urandom_range(0, 3) != 0) begin
                    BVALID = 1;
                    BRESP = slv_rsp.pop_front();
                    b_iss++;
                    if (b_budget > 0) b_budget--;
                end
            end
        end
    end

    task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic [SW-1:0] s, input logic [1:0] r);
        wr_t e;
        e.a = a;
        e.d = d;
        e.s = s;
        BUS_REQ_VALID = 1;
        BUS_ADDR = a;
        BUS_WDATA = d;
        BUS_WSTB = s;
        for (int i = 0; i < 300; i++) begin
            @(negedge ACLK);
            if (BUS_REQ_READY) begin
                if (s != '0) begin
                    exp_aw.push_back(e);
                    exp_w.push_back(e);
                    exp_rsp.push_back(r);
                    slv_rsp.push_back(r);
                end
                @(posedge ACLK);
                #1;
                BUS_REQ_VALID = 0;
                return;
            end
            @(posedge ACLK);
            #1;
        end
        check_eq("push_timeout", 64'(BUS_REQ_READY), 64'(1));
        BUS_REQ_VALID = 0;
    endtask

    task automatic drain(input string n);
        bit ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge ACLK);
            ok = exp_rsp.size() == 0 && exp_aw.size() == 0
                 && exp_w.size() == 0 && BUS_IDLE;
        end
        check_eq(n, 64'(BUS_IDLE), 64'(1));
        check_eq({n, "_left"}, 64'(exp_rsp.size()), 64'(0));
        @(posedge ACLK);
        #1;
    endtask

    task automatic split(input bit aw_first);
        int ba = aw_tot;
        int bw = w_tot;
        bit done = 0;
        aw_mode = aw_first ? 1 : 2;
        w_mode = aw_first ? 2 : 1;
        push($urandom, $urandom, 4'hF, 2'd0);
        for (int i = 0; i < 50 && !done; i++) begin
            @(posedge ACLK);
            #1;
            done = aw_first ? (aw_tot > ba) : (w_tot > bw);
        end
        check_eq("split_first_hs", 64'(done), 64'(1));
        repeat (3) begin
            @(posedge ACLK);
            #1;
        end
        @(negedge ACLK);
        check_eq("split_second_pending",
                 64'(aw_first ? WVALID : AWVALID), 64'(1));
        aw_mode = 1;
        w_mode = 1;
        drain("split_drain");
        check_eq("split_one_aw", 64'(aw_tot - ba), 64'(1));
        check_eq("split_one_w", 64'(w_tot - bw), 64'(1));
    endtask

    initial begin
        int base;
        bit seen;

        // Reset state
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        check_eq("rst_awvalid", 64'(AWVALID), 64'(0));
        check_eq("rst_wvalid", 64'(WVALID), 64'(0));
        check_eq("rst_bready", 64'(BREADY), 64'(0));
        check_eq("rst_awprot", 64'(AWPROT), 64'(0));
        check_eq("rst_rsp_valid", 64'(BUS_RSP_VALID), 64'(0));
        check_eq("rst_req_ready", 64'(BUS_REQ_READY), 64'(1));
        check_eq("rst_idle", 64'(BUS_IDLE), 64'(1));
        check_eq("rst_err", 64'(BUS_ERR), 64'(0));
        @(posedge ACLK);
        #1;
        ARESET = 0;
        @(posedge ACLK);
        #1;

        // Single write, VALIDs in the cycle after the push edge
        push(32'h100, 32'hDEADBEEF, 4'hF, 2'd0);
        @(negedge ACLK);
        check_eq("single_awvalid", 64'(AWVALID), 64'(1));
        check_eq("single_wvalid", 64'(WVALID), 64'(1));
        @(posedge ACLK);
        #1;
        drain("single_idle");

        split(1);
        split(0);

        // Outstanding limit
        base = aw_tot;
        b_budget = 0;
        for (int i = 0; i < 4; i++) push(32'h200 + 32'(4 * i), $urandom, 4'hF, 2'd0);
        repeat (6) @(posedge ACLK);
        @(negedge ACLK);
        check_eq("outst_aw_count", 64'(aw_tot - base), 64'(MAX_OUTST));
        check_eq("outst_w_count", 64'(w_tot - base), 64'(MAX_OUTST));
        check_eq("outst_awvalid_low", 64'(AWVALID), 64'(0));
        b_budget = 1;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge ACLK);
            seen = BVALID && BREADY;
        end
        check_eq("outst_b_seen", 64'(seen), 64'(1));
        @(negedge ACLK);
        check_eq("outst_slot_reuse", 64'(AWVALID), 64'(1));
        b_budget = -1;
        @(posedge ACLK);
        #1;
        drain("outst_drain");

        // Response backpressure and FIFO full
        rr_mode = 2;
        push(32'h300, $urandom, 4'hF, 2'd1);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge ACLK);
            seen = BUS_RSP_VALID;
        end
        check_eq("bp_rsp_valid", 64'(BUS_RSP_VALID), 64'(1));
        check_eq("bp_bready_low", 64'(BREADY), 64'(0));
        @(posedge ACLK);
        #1;
        aw_mode = 2;
        for (int i = 0; i < REQ_DEPTH; i++)
            push(32'h310 + 32'(4 * i), $urandom, 4'hF, 2'($urandom_range(0, 3)));
        @(negedge ACLK);
        check_eq("bp_req_full", 64'(BUS_REQ_READY), 64'(0));
        @(posedge ACLK);
        #1;
        aw_mode = 1;
        rr_mode = 1;
        drain("bp_drain");

        // Error stickiness and zero-strobe discard
        push(32'h400, 32'h1234, 4'hF, 2'd2);
        drain("err_drain");
        check_eq("err_set", 64'(BUS_ERR), 64'(1));
        push(32'h404, 32'h5678, 4'h3, 2'd0);
        drain("err_drain2");
        check_eq("err_sticky", 64'(BUS_ERR), 64'(1));
        base = aw_tot;
        push(32'h408, 32'h9ABC, 4'h0, 2'd0);
        repeat (5) @(posedge ACLK);
        @(negedge ACLK);
        check_eq("discard_no_aw", 64'(aw_tot - base), 64'(0));
        check_eq("discard_no_rsp", 64'(BUS_RSP_VALID), 64'(0));
        check_eq("discard_idle", 64'(BUS_IDLE), 64'(1));
        @(posedge ACLK);
        #1;

        // Randomized traffic
        aw_mode = 0;
        w_mode = 0;
        rr_mode = 0;
        for (int i = 0; i < 80; i++) begin
            push($urandom, $urandom,
                 ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom),
                 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge ACLK);
                #1;
            end
        end
        aw_mode = 1;
        w_mode = 1;
        rr_mode = 1;
        drain("rand_drain");

        // Reset mid-operation
        b_budget = 0;
        for (int i = 0; i < 3; i++) push(32'h500 + 32'(4 * i), $urandom, 4'hF, 2'd0);
        repeat (3) @(posedge ACLK);
        #1;
        aw_mode = 2;
        ARESET = 1;
        @(posedge ACLK);
        @(negedge ACLK);
        check_eq("mid_rst_awvalid", 64'(AWVALID), 64'(0));
        check_eq("mid_rst_wvalid", 64'(WVALID), 64'(0));
        check_eq("mid_rst_idle", 64'(BUS_IDLE), 64'(1));
        check_eq("mid_rst_err", 64'(BUS_ERR), 64'(0));
        check_eq("mid_rst_rsp", 64'(BUS_RSP_VALID), 64'(0));
        exp_aw.delete();
        exp_w.delete();
        exp_rsp.delete();
        slv_rsp.delete();
        aw_tot = 0;
        w_tot = 0;
        b_tot = 0;
        b_iss = 0;
        err_exp = 0;
        @(posedge ACLK);
        #1;
        ARESET = 0;
        aw_mode = 1;
        b_budget = -1;
        @(posedge ACLK);
        #1;
        push(32'h600, 32'hCAFEF00D, 4'hF, 2'd0);
        drain("post_rst_drain");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
